screen_msg_seq: RTL

SCREEN_MSG_SEQ -- requirements
Module: screen_msg_seq

---
 rtl/screen_msg_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/screen_msg_seq.sv
// Sends a display message (clear + note name) as serial frames per request.
// Define SCREEN_OCTAVE_EN to append the octave digit as a fifth byte.
module screen_msg_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       note_valid,
    input  logic [3:0] note_code,
    input  logic [2:0] octave,
    output logic [9:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

`ifdef SCREEN_OCTAVE_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, SEND, NEXT} state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] note_q, note_d;
    logic       pend_vld_q, pend_vld_d;
    logic [3:0] pend_note_q, pend_note_d;
`ifdef SCREEN_OCTAVE_EN
    logic [2:0] oct_q, oct_d;
    logic [2:0] pend_oct_q, pend_oct_d;
`else
    logic       unused_octave;
    assign unused_octave = ^octave;
`endif

    logic       req_ok;
    logic       xfer;
    logic       last;
    logic [7:0] letter;
    logic       sharp;
    logic [7:0] msg_byte;

    assign req_ok      = note_valid && (note_code < 4'd12);
    assign frame_valid = (state_q == SEND);
    assign xfer        = frame_valid && frame_ready;
    assign last        = (idx_q == LAST_IDX);
    assign busy        = (state_q != IDLE) || pend_vld_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            note_q      <= 4'd0;
            pend_vld_q  <= 1'b0;
            pend_note_q <= 4'd0;
`ifdef SCREEN_OCTAVE_EN
            oct_q       <= 3'd0;
            pend_oct_q  <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            note_q      <= note_d;
            pend_vld_q  <= pend_vld_d;
            pend_note_q <= pend_note_d;
`ifdef SCREEN_OCTAVE_EN
            oct_q       <= oct_d;
            pend_oct_q  <= pend_oct_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        note_d      = note_q;
        pend_vld_d  = pend_vld_q;
        pend_note_d = pend_note_q;
`ifdef SCREEN_OCTAVE_EN
        oct_d       = oct_q;
        pend_oct_d  = pend_oct_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    state_d = SEND;
                    idx_d   = 3'd0;
                    note_d  = note_code;
`ifdef SCREEN_OCTAVE_EN
                    oct_d   = octave;
`endif
                end
            end
            SEND: begin
                if (req_ok) begin
                    pend_vld_d  = 1'b1;
                    pend_note_d = note_code;
`ifdef SCREEN_OCTAVE_EN
                    pend_oct_d  = octave;
`endif
                end
                if (xfer) state_d = NEXT;
            end
            NEXT: begin
                if (!last) begin
                    state_d = SEND;
                    idx_d   = idx_q + 3'd1;
                    if (req_ok) begin
                        pend_vld_d  = 1'b1;
                        pend_note_d = note_code;
`ifdef SCREEN_OCTAVE_EN
                        pend_oct_d  = octave;
`endif
                    end
                end else if (req_ok) begin
                    // A fresh request supersedes whatever was pending
                    state_d    = SEND;
                    idx_d      = 3'd0;
                    note_d     = note_code;
                    pend_vld_d = 1'b0;
`ifdef SCREEN_OCTAVE_EN
                    oct_d      = octave;
`endif
                end else if (pend_vld_q) begin
                    state_d    = SEND;
                    idx_d      = 3'd0;
                    note_d     = pend_note_q;
                    pend_vld_d = 1'b0;
`ifdef SCREEN_OCTAVE_EN
                    oct_d      = pend_oct_q;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        letter = 8'h43;
        sharp  = 1'b0;
        case (note_q)
            4'd0:    letter = 8'h43;
            4'd1:    begin letter = 8'h43; sharp = 1'b1; end
            4'd2:    letter = 8'h44;
            4'd3:    begin letter = 8'h44; sharp = 1'b1; end
            4'd4:    letter = 8'h45;
            4'd5:    letter = 8'h46;
            4'd6:    begin letter = 8'h46; sharp = 1'b1; end
            4'd7:    letter = 8'h47;
            4'd8:    begin letter = 8'h47; sharp = 1'b1; end
            4'd9:    letter = 8'h41;
            4'd10:   begin letter = 8'h41; sharp = 1'b1; end
            4'd11:   letter = 8'h42;
            default: letter = 8'h43;
        endcase
    end

    always_comb begin
        msg_byte = 8'hFE;
        case (idx_q)
            3'd0:    msg_byte = 8'hFE;
            3'd1:    msg_byte = 8'h01;
            3'd2:    msg_byte = letter;
            3'd3:    msg_byte = sharp ? 8'h23 : 8'h20;
`ifdef SCREEN_OCTAVE_EN
            3'd4:    msg_byte = {5'b00110, oct_q};
`endif
            default: msg_byte = 8'hFE;
        endcase
    end

    assign frame_data = frame_valid ? {1'b1, msg_byte, 1'b0} : 10'h3FF;

endmodule
